pmem_burst_adaptor: RTL
=======================

Name: pmem_burst_adaptor

Overview:
Sits directly downstream of the cache interface, between its 256-bit cacheline port and the 64-bit physical memory bus.
Converts one cacheline read or write into a 4-beat burst on pmem, then returns a single-cycle line response upstream.
Holds the address and write data for the whole burst, and assembles read beats into a full line.

Parameters:
BEAT_W, 64, width of one pmem data beat.
BURST_LEN, 4, beats per cacheline; line width = BEAT_W*BURST_LEN = 256.
OFFSET_BITS, 5, low address bits forced to zero for line alignment.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
line_address  input  32  cacheline address from the cache side.
line_read  input  1  line read request; held until line_resp.
line_write  input  1  line write request; held until line_resp.
line_wdata  input  256  line to write; beat i = [64i+63:64i].
line_rdata  output  256  assembled read line.
line_resp  output  1  one-cycle completion pulse.
pmem_address  output  32  line-aligned burst address.
pmem_read  output  1  burst read request; level-held for the whole burst.
pmem_write  output  1  burst write request; level-held for the whole burst.
pmem_wdata  output  64  current write beat.
pmem_rdata  input  64  read beat data; valid when pmem_resp=1.
pmem_resp  input  1  one pulse per completed beat; beats may be non-consecutive.

Behaviour:
- Reset (asynchronous, takes effect immediately) drives the following:
  - state=IDLE, beat counter=0.
  - pmem_read=0, pmem_write=0, line_resp=0.
  - pmem_address=0, pmem_wdata=0, line_rdata=0.
  - The write buffer is cleared.
- Reset mid-burst aborts the burst with no line_resp. The partial line_rdata is cleared.
- All outputs are registered or decoded from state and registers; no input-to-output combinational path.
- IDLE:
  - Samples requests. line_read takes priority if both are high; both high is illegal upstream.
  - On read: latch pmem_address = {line_address[31:5], 5'b0}, cnt=0, go to READ.
  - On write: latch the same address, latch line_wdata into the write buffer, cnt=0, go to WRITE.
- READ:
  - pmem_read=1 and pmem_address are held stable.
  - On each pmem_resp=1: line_rdata[64*cnt +: 64] <= pmem_rdata, cnt++.
  - On the beat with cnt==3, go to DONE.
- WRITE:
  - pmem_write=1.
  - pmem_wdata = wbuf[64*cnt +: 64], so beat 0 is presented in the first WRITE cycle.
  - On each pmem_resp: cnt++. After beat 3 is acknowledged, go to DONE.
- DONE:
  - line_resp=1 for exactly one cycle; pmem_read=pmem_write=0.
  - Next state is always IDLE. A request still high in DONE is not restarted.
  - The upstream side drops its request on the edge where it sees line_resp.
- Minimum latency: request seen at edge 0, 4 consecutive beats → line_resp high in cycle 5. The total round trip is 6 cycles.
- line_rdata holds its last assembled line until the next read burst overwrites beat 0.
- pmem_wdata=0 outside WRITE.
- pmem_resp is ignored in IDLE and DONE. Stray responses never advance cnt.
- cnt is 2 bits and wraps 3→0 only on the final beat. No beat count other than 4 exists.
- Changes to line_address or line_wdata during a burst have no effect; the latched copies are used.

Test Plan:
- Read burst: line_read=1, line_address=0x1234_567C; pmem returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles → pmem_address=0x1234_5660 throughout. line_rdata={0x44..,0x33..,0x22..,0x11..}, line_resp pulses in cycle 5 for one cycle.
- Write burst: line_write=1, line_wdata beats 0xA0..,0xB1..,0xC2..,0xD3..; pmem_resp with 2 idle cycles between beats → pmem_wdata steps through A0,B1,C2,D3 in order, changing only after each resp. pmem_write stays high until the final beat, then one line_resp.
- Stray/late responses: pmem_resp pulsed in IDLE and in DONE → cnt unchanged, no pmem request, no line_resp. The next read still captures 4 beats correctly.
- Input instability: change line_address and line_wdata to 0xFFFF_FFFF after acceptance → pmem_address and pmem_wdata keep the latched values.
- Reset mid-read after 2 beats: rst asserted asynchronously between edges → pmem_read drops immediately, line_rdata=0, and no line_resp. After release, a fresh read completes normally.
- Back-to-back: read then write requested on the cycle after line_resp → each performs a full 4-beat burst, with exactly one IDLE cycle between them.

Source files
------------

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: turns a 256-bit cacheline read/write into a 4-beat
// 64-bit burst on physical memory and returns a one-cycle line response.
module pmem_burst_adaptor #(
    parameter int unsigned BEAT_W      = 64,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 line_address,
    input  logic                        line_read,
    input  logic                        line_write,
    input  logic [BEAT_W*BURST_LEN-1:0] line_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] line_rdata,
    output logic                        line_resp,
    output logic [31:0]                 pmem_address,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [BEAT_W-1:0]           pmem_wdata,
    input  logic [BEAT_W-1:0]           pmem_rdata,
    input  logic                        pmem_resp
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((2 ** OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   next_cnt;
    logic [BURST_LEN-1:0][BEAT_W-1:0]   wbuf;
    logic [BURST_LEN-1:0][BEAT_W-1:0]   rbuf;

    assign next_cnt   = cnt + CNT_W'(1);
    assign line_rdata = rbuf;

    // Burst sequencer: latches the request, walks the beats, pulses line_resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wbuf         <= '0;
            rbuf         <= '0;
            line_resp    <= 1'b0;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
        end else begin
            line_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_read) begin
                        pmem_address <= line_address & ALIGN_MASK;
                        cnt          <= '0;
                        pmem_read    <= 1'b1;
                        state        <= READ;
                    end else if (line_write) begin
                        pmem_address <= line_address & ALIGN_MASK;
                        wbuf         <= line_wdata;
                        pmem_wdata   <= line_wdata[BEAT_W-1:0];
                        cnt          <= '0;
                        pmem_write   <= 1'b1;
                        state        <= WRITE;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        rbuf[cnt] <= pmem_rdata;
                        cnt       <= next_cnt;
                        if (cnt == LAST_BEAT) begin
                            pmem_read <= 1'b0;
                            line_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (pmem_resp) begin
                        cnt <= next_cnt;
                        if (cnt == LAST_BEAT) begin
                            pmem_write <= 1'b0;
                            pmem_wdata <= '0;
                            line_resp  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pmem_wdata <= wbuf[next_cnt];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
